// File: rtl/sr_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sr_bank_arbiter
// Description : Round-robin arbitrated bank of set/reset flags with exported
//               registered S/R strobes. Optional conflict counter enabled by
//               defining SRB_CONFLICT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 6,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NBITS-1:0]     s_out,
    output logic [NBITS-1:0]     r_out,
    output logic [NBITS-1:0]     q,
    output logic [NBITS-1:0]     qb,
    output logic                 err
`ifdef SRB_CONFLICT_CNT_EN
    ,
    output logic [7:0]           conflict_cnt
`endif
);

    localparam int                c_ptr_w   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NBITS-1:0]  c_bit_one = NBITS'(1);
    localparam logic [NREQ-1:0]   c_req_one = NREQ'(1);

    logic [c_ptr_w-1:0] r_ptr;
    logic [NREQ-1:0]    r_gnt;
    logic [NBITS-1:0]   r_s;
    logic [NBITS-1:0]   r_r;
    logic [NBITS-1:0]   r_q;
    logic               r_err;

    logic [NREQ-1:0]    w_elig;
    logic               w_found;
    logic [c_ptr_w-1:0] w_win;
    logic [c_ptr_w-1:0] w_cand;
    logic [IDXW-1:0]    w_idx;
    logic               w_op;
    logic               w_in_range;
    logic [NBITS-1:0]   w_bit_oh;

    // Last cycle's winner sits out one cycle so it cannot monopolise the bank.
    assign w_elig = req & ~r_gnt;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = c_ptr_w'((32'(r_ptr) + 32'(k)) % NREQ);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_idx      = idx[32'(w_win)*IDXW +: IDXW];
    assign w_op       = op[w_win];
    assign w_in_range = (32'(w_idx) < NBITS);
    assign w_bit_oh   = c_bit_one << w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_s   <= '0;
            r_r   <= '0;
            r_q   <= '0;
            r_err <= 1'b0;
        end else if (w_found) begin
            r_gnt <= c_req_one << w_win;
            r_ptr <= c_ptr_w'((32'(w_win) + 32'd1) % NREQ);
            if (w_in_range) begin
                r_err <= 1'b0;
                if (w_op) begin
                    r_q <= r_q & ~w_bit_oh;
                    r_r <= w_bit_oh;
                    r_s <= '0;
                end else begin
                    r_q <= r_q | w_bit_oh;
                    r_s <= w_bit_oh;
                    r_r <= '0;
                end
            end else begin
                // Out-of-range command is still consumed, only flagged.
                r_err <= 1'b1;
                r_s   <= '0;
                r_r   <= '0;
            end
        end else begin
            r_gnt <= '0;
            r_s   <= '0;
            r_r   <= '0;
            r_err <= 1'b0;
        end
    end

    assign gnt   = r_gnt;
    assign s_out = r_s;
    assign r_out = r_r;
    assign q     = r_q;
    assign qb    = ~r_q;
    assign err   = r_err;

`ifdef SRB_CONFLICT_CNT_EN
    logic [NBITS-1:0] w_set_tgt;
    logic [NBITS-1:0] w_clr_tgt;
    logic [IDXW-1:0]  w_ci;
    logic [7:0]       r_conflict_cnt;

    // A conflict is any in-range bit targeted by both a set and a clear.
    always_comb begin
        w_set_tgt = '0;
        w_clr_tgt = '0;
        w_ci      = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ci = idx[i*IDXW +: IDXW];
            if (w_elig[i] && (32'(w_ci) < NBITS)) begin
                if (op[i]) begin
                    w_clr_tgt = w_clr_tgt | (c_bit_one << w_ci);
                end else begin
                    w_set_tgt = w_set_tgt | (c_bit_one << w_ci);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= 8'd0;
        end else if ((|(w_set_tgt & w_clr_tgt)) && (r_conflict_cnt != 8'hFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_bank_arbiter
// Description : Directed-vector scoreboard bench for sr_bank_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic [5:0]  s_out;
    logic [5:0]  r_out;
    logic [5:0]  q;
    logic [5:0]  qb;
    logic        err;
`ifdef SRB_CONFLICT_CNT_EN
    logic [7:0]  conflict_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [5:0] s;
        logic [5:0] r;
        logic [5:0] q;
        logic       err;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    sr_bank_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .idx   (idx),
        .gnt   (gnt),
        .s_out (s_out),
        .r_out (r_out),
        .q     (q),
        .qb    (qb),
        .err   (err)
`ifdef SRB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pk(int a0, int a1, int a2, int a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    // Drive one cycle of stimulus and queue what must appear after the edge.
    task automatic vec(input logic r, input logic [3:0] rq, input logic [3:0] o,
                       input logic [11:0] ix, input logic [3:0] eg,
                       input logic [5:0] es, input logic [5:0] er,
                       input logic [5:0] eq, input logic ee,
                       input logic [7:0] ec, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; req = rq; op = o; idx = ix;
        e.gnt = eg; e.s = es; e.r = er; e.q = eq; e.err = ee; e.cnt = ec; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: every edge that has a queued expectation is checked 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({gnt, s_out, r_out, q, qb, err} !== {e.gnt, e.s, e.r, e.q, ~e.q, e.err}) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b s=%b r=%b q=%b qb=%b err=%b, want gnt=%b s=%b r=%b q=%b qb=%b err=%b",
                             e.name, gnt, s_out, r_out, q, qb, err,
                             e.gnt, e.s, e.r, e.q, ~e.q, e.err);
                end
                if ((s_out & r_out) != 6'd0) begin
                    n_fail++;
                    $display("FAIL %s_sr_overlap: got s=%b r=%b, want disjoint", e.name, s_out, r_out);
                end
`ifdef SRB_CONFLICT_CNT_EN
                n_checks++;
                if (conflict_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s_cnt: got %0d, want %0d", e.name, conflict_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = 4'b0000; op = 4'b0000; idx = 12'd0;

        // Reset with all requesters active: nothing granted.
        vec(1, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd0, "rst_a");
        vec(1, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd0, "rst_b");
        // Continuous all-request rotation 0,1,2,3,0.
        vec(0, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0001, 6'b000001, 6'b0, 6'b000001, 0, 8'd0, "rr0");
        vec(0, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0010, 6'b000010, 6'b0, 6'b000011, 0, 8'd0, "rr1");
        vec(0, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0100, 6'b000100, 6'b0, 6'b000111, 0, 8'd0, "rr2");
        vec(0, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b1000, 6'b001000, 6'b0, 6'b001111, 0, 8'd0, "rr3");
        vec(0, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0001, 6'b000001, 6'b0, 6'b001111, 0, 8'd0, "rr4");
        vec(0, 4'b0000, 4'b0000, pk(0,1,2,3), 4'b0000, 6'b0, 6'b0, 6'b001111, 0, 8'd0, "idle0");
        vec(1, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd0, "rst_c");
        // Requester 2 sets then clears bit 5; new command is masked for one cycle.
        vec(0, 4'b0100, 4'b0000, pk(0,0,5,0), 4'b0100, 6'b100000, 6'b0, 6'b100000, 0, 8'd0, "set5");
        vec(0, 4'b0100, 4'b0100, pk(0,0,5,0), 4'b0000, 6'b0, 6'b0, 6'b100000, 0, 8'd0, "mask");
        vec(0, 4'b0100, 4'b0100, pk(0,0,5,0), 4'b0100, 6'b0, 6'b100000, 6'b000000, 0, 8'd0, "clr5");
        vec(0, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd0, "idle1");
        vec(1, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd0, "rst_d");
        // Opposite set/clear on bit 1: req0 first, then req1.
        vec(0, 4'b0011, 4'b0010, pk(1,1,0,0), 4'b0001, 6'b000010, 6'b0, 6'b000010, 0, 8'd1, "cf_set");
        vec(0, 4'b0010, 4'b0010, pk(1,1,0,0), 4'b0010, 6'b0, 6'b000010, 6'b000000, 0, 8'd1, "cf_clr");
        vec(0, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd1, "idle2");
        // Out-of-range index: granted, flagged, no strobe.
        vec(0, 4'b1000, 4'b0000, pk(0,0,0,7), 4'b1000, 6'b0, 6'b0, 6'b000000, 1, 8'd1, "oor");
        vec(0, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd1, "err_clr");
        // Move ptr off zero so reset of ptr is observable.
        vec(0, 4'b0100, 4'b0000, pk(0,0,4,0), 4'b0100, 6'b010000, 6'b0, 6'b010000, 0, 8'd1, "set4");
        vec(0, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 6'b0, 6'b0, 6'b010000, 0, 8'd1, "idle3");
        vec(1, 4'b0010, 4'b0000, pk(0,2,0,0), 4'b0000, 6'b0, 6'b0, 6'b000000, 0, 8'd0, "rst_pend");
        vec(0, 4'b1010, 4'b0000, pk(0,2,0,0), 4'b0010, 6'b000100, 6'b0, 6'b000100, 0, 8'd0, "ptr0");
        vec(0, 4'b1000, 4'b0000, pk(0,2,0,0), 4'b1000, 6'b000001, 6'b0, 6'b000101, 0, 8'd0, "set0");
        // Setting an already-set bit still grants and strobes.
        vec(0, 4'b0010, 4'b0000, pk(0,2,0,0), 4'b0010, 6'b000100, 6'b0, 6'b000101, 0, 8'd0, "idem");
        vec(0, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 6'b0, 6'b0, 6'b000101, 0, 8'd0, "idle4");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

`ifdef SRB_CONFLICT_CNT_EN
        // Every cycle at least one set and one clear on bit 1 stay eligible.
        @(negedge clk);
        req = 4'b1111; op = 4'b1010; idx = pk(1,1,1,1);
        repeat (300) @(negedge clk);
        req = 4'b0000;
        n_checks++;
        if (conflict_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL cnt_sat: got %0d, want 255", conflict_cnt);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
